framed_byte_tx: RTL and testbench



---
 rtl/framed_byte_tx.sv | 130 +++++++++++++
 tb/tb_framed_byte_tx.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/framed_byte_tx.sv
`default_nettype none
// ============================================================================
// Module      : framed_byte_tx
// Description : Buffers DEPTH payload bytes and then sends them as one frame:
//               a header byte, then the payload, with the last byte flagged.
// Revision    : 1.0 - initial release
// ============================================================================
module framed_byte_tx #(
    parameter int               DEPTH = 8,
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] HDR   = 8'h01
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    input  logic             out_ready,
    output logic             busy,
    output logic [7:0]       frame_cnt
);

    localparam int               c_PTR_W = $clog2(DEPTH);
    localparam logic [c_PTR_W-1:0] c_LAST = c_PTR_W'(DEPTH - 1);
    localparam logic [c_PTR_W-1:0] c_ONE  = c_PTR_W'(1);

    typedef enum logic [1:0] {
        S_FILL   = 2'd0,
        S_HEADER = 2'd1,
        S_SEND   = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_PTR_W-1:0]   r_wptr;
    logic [c_PTR_W-1:0]   w_wptr_nxt;
    logic [c_PTR_W-1:0]   r_rptr;
    logic [c_PTR_W-1:0]   w_rptr_nxt;
    logic [7:0]           r_frame_cnt;
    logic [7:0]           w_frame_cnt_nxt;
    logic                 w_wr_en;
    logic [WIDTH-1:0]     r_mem [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_FILL;
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_frame_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_wptr      <= w_wptr_nxt;
            r_rptr      <= w_rptr_nxt;
            r_frame_cnt <= w_frame_cnt_nxt;
        end
    end

    // Payload storage carries no reset; only the pointers define its contents.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wptr] <= in_data;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_wptr_nxt      = r_wptr;
        w_rptr_nxt      = r_rptr;
        w_frame_cnt_nxt = r_frame_cnt;
        w_wr_en         = 1'b0;
        in_ready        = 1'b0;
        out_valid       = 1'b0;
        out_data        = '0;
        out_last        = 1'b0;

        case (r_state)
            S_FILL: begin
                in_ready = 1'b1;
                if (in_valid && !flush) begin
                    w_wr_en    = 1'b1;
                    w_wptr_nxt = r_wptr + c_ONE;
                    if (r_wptr == c_LAST) begin
                        w_state_nxt = S_HEADER;
                    end
                end
            end
            S_HEADER: begin
                out_valid = 1'b1;
                out_data  = HDR;
                if (out_ready) begin
                    w_state_nxt = S_SEND;
                    w_rptr_nxt  = '0;
                end
            end
            S_SEND: begin
                out_valid = 1'b1;
                out_data  = r_mem[r_rptr];
                out_last  = (r_rptr == c_LAST);
                if (out_ready) begin
                    w_rptr_nxt = r_rptr + c_ONE;
                    if (r_rptr == c_LAST) begin
                        w_state_nxt = S_DONE;
                    end
                end
            end
            default: begin
                w_frame_cnt_nxt = r_frame_cnt + 8'd1;
                w_state_nxt     = S_FILL;
            end
        endcase

        // Abort overrides every transition but leaves the frame count alone.
        if (flush) begin
            w_state_nxt     = S_FILL;
            w_wptr_nxt      = '0;
            w_rptr_nxt      = '0;
            w_frame_cnt_nxt = r_frame_cnt;
        end
    end

    assign busy      = (r_state != S_FILL);
    assign frame_cnt = r_frame_cnt;

endmodule
`default_nettype wire

// File: tb/tb_framed_byte_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_framed_byte_tx
// Description : Directed self-checking bench for framed_byte_tx.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_framed_byte_tx;

    localparam logic [7:0] c_HDR = 8'h01;

    logic       clk;
    logic       rst_n;
    logic       flush;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_last;
    logic       out_ready;
    logic       busy;
    logic [7:0] frame_cnt;

    int         errors;
    int         checks;
    logic [7:0] exp_cnt;

    framed_byte_tx #(
        .DEPTH (8),
        .WIDTH (8),
        .HDR   (c_HDR)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_ready (out_ready),
        .busy      (busy),
        .frame_cnt (frame_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer n bytes base, base+1, ... with in_valid high one cycle in every period.
    task automatic fill(input logic [7:0] base, input int period, input int n);
        int acc = 0;
        int cyc = 0;
        while (acc < n && cyc < 100) begin
            in_valid = ((cyc % period) == 0);
            in_data  = in_valid ? base + acc[7:0] : 8'h00;
            check("fill_in_ready", {31'd0, in_ready}, 32'd1);
            check("fill_out_valid", {31'd0, out_valid}, 32'd0);
            tick();
            if (in_valid) acc++;
            cyc++;
        end
        if (acc < n) check("fill_timeout", acc, n);
    endtask

    // Consume header + 8 payload bytes; stall toggles out_ready 1,0,1,0...
    task automatic drain(input logic [7:0] base, input bit stall, input int exp_cycles);
        int         k = 0;
        int         cyc = 0;
        int         idx;
        logic [7:0] exp_b;
        while (k < 9 && cyc < 60) begin
            out_ready = stall ? ((cyc % 2) == 0) : 1'b1;
            idx       = k - 1;
            exp_b     = (k == 0) ? c_HDR : base + idx[7:0];
            check("out_valid", {31'd0, out_valid}, 32'd1);
            check("out_data", {24'd0, out_data}, {24'd0, exp_b});
            check("out_last", {31'd0, out_last}, (k == 8) ? 32'd1 : 32'd0);
            check("send_in_ready", {31'd0, in_ready}, 32'd0);
            check("send_busy", {31'd0, busy}, 32'd1);
            if (out_valid && out_ready) k++;
            tick();
            cyc++;
        end
        check("drain_cycles", cyc, exp_cycles);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check("done_out_valid", {31'd0, out_valid}, 32'd0);
        check("done_out_data", {24'd0, out_data}, 32'd0);
        check("done_in_ready", {31'd0, in_ready}, 32'd0);
        check("done_busy", {31'd0, busy}, 32'd1);
        tick();
        exp_cnt = exp_cnt + 8'd1;
        check("in_ready_back", {31'd0, in_ready}, 32'd1);
        check("frame_cnt", {24'd0, frame_cnt}, {24'd0, exp_cnt});
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        exp_cnt   = 8'd0;
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b0;

        // Reset values while reset is held
        tick();
        tick();
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_data", {24'd0, out_data}, 32'd0);
        check("rst_out_last", {31'd0, out_last}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_frame_cnt", {24'd0, frame_cnt}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Frame 1: in_valid held high, full-rate output
        fill(8'h10, 1, 8);
        check("s1_in_ready_low", {31'd0, in_ready}, 32'd0);
        drain(8'h10, 1'b0, 9);

        // Frame 2: same data with out_ready toggling
        fill(8'h10, 1, 8);
        drain(8'h10, 1'b1, 17);

        // Frame 3: in_valid every third cycle
        fill(8'h30, 3, 8);
        drain(8'h30, 1'b0, 9);

        // Flush after 5 bytes (with in_valid still high), then a fresh frame
        fill(8'h70, 1, 5);
        in_valid = 1'b1;
        in_data  = 8'hEE;
        flush    = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_fill_busy", {31'd0, busy}, 32'd0);
        check("flush_fill_cnt", {24'd0, frame_cnt}, {24'd0, exp_cnt});
        fill(8'hA0, 1, 8);
        drain(8'hA0, 1'b0, 9);

        // Flush in SEND after 3 payload bytes
        fill(8'h50, 1, 8);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        check("send_byte3", {24'd0, out_data}, 32'h53);
        out_ready = 1'b0;
        flush     = 1'b1;
        tick();
        flush     = 1'b0;
        check("flush_out_valid", {31'd0, out_valid}, 32'd0);
        check("flush_in_ready", {31'd0, in_ready}, 32'd1);
        check("flush_frame_cnt", {24'd0, frame_cnt}, {24'd0, exp_cnt});

        // Asynchronous reset mid-SEND takes effect before the next edge
        fill(8'h60, 1, 8);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("arst_in_ready", {31'd0, in_ready}, 32'd1);
        check("arst_out_valid", {31'd0, out_valid}, 32'd0);
        check("arst_out_data", {24'd0, out_data}, 32'd0);
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_frame_cnt", {24'd0, frame_cnt}, 32'd0);
        exp_cnt   = 8'd0;
        out_ready = 1'b0;
        #2;
        rst_n = 1'b1;
        tick();

        // 256 back-to-back frames: counter wraps back to zero
        for (int f = 0; f < 256; f++) begin
            fill(f[7:0], 1, 8);
            drain(f[7:0], 1'b0, 9);
        end
        check("wrap_frame_cnt", {24'd0, frame_cnt}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
